// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared definitions for the nRisc multicycle core.
//   - opcode values of the 16-bit instruction word (op field, bits [15:12])
//   - FSM state enumeration
//   - ALU operation codes
//   - isIllegal(): true for the reserved opcodes 0xB..0xE
package nrisc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_LI   = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JR   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } aluOp_t;

  function automatic logic isIllegal(input logic [3:0] op);
    return op inside {4'hB, 4'hC, 4'hD, 4'hE};
  endfunction

endpackage

// File: rtl/nrisc_alu.sv
// nrisc_alu: combinational ALU of the nRisc core.
//   aluOp  in   operation select (ADD, SUB, AND, OR, SLT)
//   a, b   in   DATA_W operands
//   y      out  DATA_W result, modulo 2^DATA_W
//   equal  out  a == b, used by BEQ
module nrisc_alu
  import nrisc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  aluOp_t            aluOp,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              equal
);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    y = '0;
    case (aluOp)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = DATA_W'($signed(a) < $signed(b));
      default: y = '0;
    endcase
  end

  assign equal = (a == b);

endmodule

// File: rtl/nrisc_mc.sv
// nrisc_mc: multicycle nRisc core with Harvard req/ack memory ports.
//   Clock, Reset   rising-edge clock, asynchronous active-low reset
//   IReq/IAddr     instruction fetch request and address (IAddr == PC)
//   IAck/IRData    fetch completion and instruction word
//   DReq/DWe       data access request, 1 = store
//   DAddr/DWData   data address and store data, stable while DReq is high
//   DAck/DRData    data access completion and load data
//   Halted         core stopped (HALT or illegal opcode)
//   Illegal        the stop came from an illegal opcode
module nrisc_mc
  import nrisc_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              IReq,
  output logic [PC_W-1:0]   IAddr,
  input  logic              IAck,
  input  logic [15:0]       IRData,
  output logic              DReq,
  output logic              DWe,
  output logic [DATA_W-1:0] DAddr,
  output logic [DATA_W-1:0] DWData,
  input  logic              DAck,
  input  logic [DATA_W-1:0] DRData,
  output logic              Halted,
  output logic              Illegal
);

  state_t            state, stateNext;
  logic [PC_W-1:0]   pc, pcPlus1, pcNext;
  logic [15:0]       ir;
  logic [DATA_W-1:0] a, b, res, mdr;
  logic [DATA_W-1:0] regs [16];
  logic              running;
  logic              illegalQ;

  logic [3:0] op, rd, rs, rt;
  assign op = ir[15:12];
  assign rd = ir[11:8];
  assign rs = ir[7:4];
  assign rt = ir[3:0];

  logic              isMem;
  aluOp_t            aluOp;
  logic [DATA_W-1:0] aluB, aluY;
  logic              aluEqual;

  assign isMem = (op == OP_LW) || (op == OP_SW);
  assign aluB  = isMem ? DATA_W'($signed(ir[3:0])) : b;

  always_comb begin
    aluOp = ALU_ADD;
    case (op)
      OP_SUB:  aluOp = ALU_SUB;
      OP_AND:  aluOp = ALU_AND;
      OP_OR:   aluOp = ALU_OR;
      OP_SLT:  aluOp = ALU_SLT;
      default: aluOp = ALU_ADD;
    endcase
  end

  nrisc_alu #(.DATA_W(DATA_W)) uAlu (
    .aluOp (aluOp),
    .a     (a),
    .b     (aluB),
    .y     (aluY),
    .equal (aluEqual)
  );

  // Branch offsets are sign-extended to PC_W; the JR cast zero-extends or
  // truncates the register value to the PC width.
  assign pcPlus1 = pc + 1'b1;
  always_comb begin
    pcNext = pcPlus1;
    case (op)
      OP_BEQ:  pcNext = aluEqual ? pcPlus1 + PC_W'($signed(ir[3:0])) : pcPlus1;
      OP_JMP:  pcNext = pcPlus1 + PC_W'($signed(ir[7:0]));
      OP_JR:   pcNext = PC_W'(a);
      default: pcNext = pcPlus1;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_FETCH;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_FETCH:  if (IReq && IAck) stateNext = S_DECODE;
      S_DECODE: stateNext = (op == OP_HALT || isIllegal(op)) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (op == OP_BEQ || op == OP_JMP || op == OP_JR) stateNext = S_FETCH;
        else if (isMem)                                  stateNext = S_MEM;
        else                                             stateNext = S_WB;
      end
      S_MEM:    if (DAck) stateNext = (op == OP_SW) ? S_FETCH : S_WB;
      S_WB:     stateNext = S_FETCH;
      S_HALT:   stateNext = S_HALT;
      default:  stateNext = S_FETCH;
    endcase
  end

  // The register file is cleared on reset because the core guarantees all
  // registers read 0 after reset. r0 is never written, so it stays 0.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      res      <= '0;
      mdr      <= '0;
      running  <= 1'b0;
      illegalQ <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      // running holds IReq low until the first edge after reset release.
      running <= 1'b1;
      case (state)
        S_FETCH:  if (IReq && IAck) ir <= IRData;
        S_DECODE: begin
          a <= regs[rs];
          b <= (op == OP_SW || op == OP_BEQ) ? regs[rd] : regs[rt];
          if (isIllegal(op)) illegalQ <= 1'b1;
        end
        S_EXEC: begin
          res <= (op == OP_LI) ? DATA_W'($signed(ir[7:0])) : aluY;
          pc  <= pcNext;
        end
        S_MEM:    if (DAck && op == OP_LW) mdr <= DRData;
        S_WB:     if (rd != 4'd0) regs[rd] <= (op == OP_LW) ? mdr : res;
        default:  ;
      endcase
    end
  end

  assign IReq    = running && (state == S_FETCH);
  assign IAddr   = pc;
  assign DReq    = (state == S_MEM);
  assign DWe     = (state == S_MEM) && (op == OP_SW);
  assign DAddr   = res;
  assign DWData  = b;
  assign Halted  = (state == S_HALT);
  assign Illegal = illegalQ;

endmodule
